fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly downstream of instcache and upstream of decode.
- Holds the PC and issues block-aligned requests to the cache.
- Buffers the returned block in a one-line buffer and feeds 32-bit instructions to decode over a valid/ready handshake.
- Handles control-flow redirects, including discarding a response that is already in flight.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, requests 128-bit blocks from instcache,
// buffers one line and feeds decode. Optional FETCH_PERF_EN adds perf counters.
module fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter int                 INST_W   = 32,
    parameter int                 BLOCK_W  = 128,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [ADDR_W-1:0]   req_addr,
    input  logic                resp_valid,
    input  logic [BLOCK_W-1:0]  resp_block,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst,
    output logic [ADDR_W-1:0]   inst_pc,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [2:0]          state_dbg
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]         perf_fetch_cnt,
    output logic [15:0]         perf_stall_cnt
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds valid and payload stable until then, unless a redirect flushes.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        SERVE = 3'd4
    } state_t;

    localparam int TAG_W = ADDR_W - 4;

    state_t               state, state_next;
    logic [ADDR_W-1:0]    pc, pc_next;
    logic [BLOCK_W-1:0]   lb_data;
    logic [TAG_W-1:0]     lb_tag;
    logic                 lb_valid;
    logic                 capture;
    logic [ADDR_W-1:0]    rd_pc;
    logic [ADDR_W-1:0]    pc_inc;
    logic                 rd_hit;

    assign rd_pc     = redirect_pc & ~ADDR_W'(3);
    assign rd_hit    = lb_valid && (rd_pc[ADDR_W-1:4] == lb_tag);
    assign pc_inc    = pc + ADDR_W'(4);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            lb_data  <= '0;
            lb_tag   <= '0;
            lb_valid <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture) begin
                lb_data  <= resp_block;
                lb_tag   <= pc[ADDR_W-1:4];
                lb_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = '0;
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                req_valid = 1'b1;
                req_addr  = {pc[ADDR_W-1:4], 4'b0000};
                if (redirect) begin
                    pc_next    = rd_pc;
                    state_next = rd_hit ? SERVE : FETCH;
                end else if (req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_next = rd_pc;
                    if (resp_valid) state_next = rd_hit ? SERVE : FETCH;
                    else            state_next = DRAIN;
                end else if (resp_valid) begin
                    capture    = 1'b1;
                    state_next = SERVE;
                end
            end
            DRAIN: begin
                // A redirect only moves the target; the stale response still has to be swallowed.
                if (redirect)   pc_next    = rd_pc;
                if (resp_valid) state_next = FETCH;
            end
            SERVE: begin
                inst_valid = 1'b1;
                inst       = lb_data[int'(pc[3:2]) * INST_W +: INST_W];
                inst_pc    = pc;
                if (redirect) begin
                    pc_next    = rd_pc;
                    state_next = rd_hit ? SERVE : FETCH;
                end else if (inst_ready) begin
                    pc_next = pc_inc;
                    if (pc_inc[ADDR_W-1:4] != lb_tag) state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (req_valid && req_ready && perf_fetch_cnt != 16'hFFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if ((state == FETCH || state == WAIT || state == DRAIN) && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance at RESET_PC=0x00, a second at 0xF0
// for the PC wrap case.
module tb_fetch_unit;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_SERVE = 3'd4;

    logic         clk = 1'b0;
    logic         rst;
    logic         w_rst;
    logic         req_ready;
    logic         resp_valid;
    logic [127:0] resp_block;
    logic         inst_ready;
    logic         redirect;
    logic [7:0]   redirect_pc;

    logic         req_valid, inst_valid;
    logic [7:0]   req_addr, inst_pc;
    logic [31:0]  inst;
    logic [2:0]   state_dbg;

    logic         w_req_valid, w_inst_valid;
    logic [7:0]   w_req_addr, w_inst_pc;
    logic [31:0]  w_inst;
    logic [2:0]   w_state_dbg;

`ifdef FETCH_PERF_EN
    logic [15:0]  perf_fetch_cnt, perf_stall_cnt;
    logic [15:0]  w_perf_fetch_cnt, w_perf_stall_cnt;
`endif

    logic [127:0] blk0 = 128'h44444444_33333333_22222222_11111111;
    logic [127:0] blka = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
    logic [127:0] blkb = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    logic [31:0]  w0 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .INST_W(32), .BLOCK_W(128), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_block(resp_block),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .state_dbg(state_dbg)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    fetch_unit #(.ADDR_W(8), .INST_W(32), .BLOCK_W(128), .RESET_PC(8'hF0)) u_wrap (
        .clk(clk), .rst(w_rst),
        .req_valid(w_req_valid), .req_ready(req_ready), .req_addr(w_req_addr),
        .resp_valid(resp_valid), .resp_block(resp_block),
        .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .state_dbg(w_state_dbg)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_stall_cnt(w_perf_stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_ready = 1'b1;
        step(); step();
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0b exp=0", req_valid); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%0b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
        checks++; if (inst_pc !== 8'h00) begin failures++; $display("FAIL rst_inst_pc got=%h exp=00", inst_pc); end
        checks++; if (req_addr !== 8'h00) begin failures++; $display("FAIL rst_req_addr got=%h exp=00", req_addr); end
        checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
        rst = 1'b0;
        step();
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%0b exp=1", req_valid); end
        checks++; if (req_addr !== 8'h00) begin failures++; $display("FAIL first_req_addr got=%h exp=00", req_addr); end
        step();
        checks++; if (state_dbg !== S_WAIT) begin failures++; $display("FAIL first_wait_state got=%0d exp=%0d", state_dbg, S_WAIT); end
        resp_valid = 1'b1; resp_block = blk0; inst_ready = 1'b1;
        step();
        resp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL serve%0d_valid got=%0b exp=1", k, inst_valid); end
            checks++; if (inst !== w0[k]) begin failures++; $display("FAIL serve%0d_inst got=%h exp=%h", k, inst, w0[k]); end
            checks++; if (inst_pc !== 8'(k * 4)) begin failures++; $display("FAIL serve%0d_pc got=%h exp=%h", k, inst_pc, 8'(k * 4)); end
            step();
        end
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL next_req_valid got=%0b exp=1", req_valid); end
        checks++; if (req_addr !== 8'h10) begin failures++; $display("FAIL next_req_addr got=%h exp=10", req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL next_inst_valid got=%0b exp=0", inst_valid); end
        req_ready = 1'b0; inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        redirect = 1'b1; redirect_pc = 8'h04;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_valid got=%0b exp=1", i, inst_valid); end
            checks++; if (inst !== 32'h22222222) begin failures++; $display("FAIL bp%0d_inst got=%h exp=22222222", i, inst); end
            checks++; if (inst_pc !== 8'h04) begin failures++; $display("FAIL bp%0d_pc got=%h exp=04", i, inst_pc); end
            checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL bp%0d_req got=%0b exp=0", i, req_valid); end
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++; if (inst_pc !== 8'h08) begin failures++; $display("FAIL bp_release_pc got=%h exp=08", inst_pc); end
        checks++; if (inst !== 32'h33333333) begin failures++; $display("FAIL bp_release_inst got=%h exp=33333333", inst); end
    endtask

    task automatic test_lb_hit();
        redirect = 1'b1; redirect_pc = 8'h00;
        step();
        checks++; if (inst_pc !== 8'h00) begin failures++; $display("FAIL hit0_pc got=%h exp=00", inst_pc); end
        checks++; if (inst !== 32'h11111111) begin failures++; $display("FAIL hit0_inst got=%h exp=11111111", inst); end
        redirect_pc = 8'h08;
        step();
        checks++; if (inst_pc !== 8'h08) begin failures++; $display("FAIL hit8_pc got=%h exp=08", inst_pc); end
        checks++; if (inst !== 32'h33333333) begin failures++; $display("FAIL hit8_inst got=%h exp=33333333", inst); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL hit8_req got=%0b exp=0", req_valid); end
        redirect_pc = 8'h0E;
        step();
        redirect = 1'b0;
        checks++; if (inst_pc !== 8'h0C) begin failures++; $display("FAIL hitE_pc got=%h exp=0C", inst_pc); end
        checks++; if (inst !== 32'h44444444) begin failures++; $display("FAIL hitE_inst got=%h exp=44444444", inst); end
    endtask

    task automatic test_redirect_wait();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++; if (req_addr !== 8'h10) begin failures++; $display("FAIL rw_req_addr got=%h exp=10", req_addr); end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 8'h23;
        step();
        redirect = 1'b0;
        checks++; if (state_dbg !== S_DRAIN) begin failures++; $display("FAIL rw_state got=%0d exp=%0d", state_dbg, S_DRAIN); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rw_drain_valid got=%0b exp=0", inst_valid); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rw_drain_req got=%0b exp=0", req_valid); end
        resp_valid = 1'b1; resp_block = blka;
        step();
        resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rw_discard_valid got=%0b exp=0", inst_valid); end
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL rw_refetch_req got=%0b exp=1", req_valid); end
        checks++; if (req_addr !== 8'h20) begin failures++; $display("FAIL rw_refetch_addr got=%h exp=20", req_addr); end
        // Old line (tag 0) must still be resident if block A was discarded.
        redirect = 1'b1; redirect_pc = 8'h04;
        step();
        checks++; if (inst !== 32'h22222222) begin failures++; $display("FAIL rw_oldline_inst got=%h exp=22222222", inst); end
        checks++; if (inst_pc !== 8'h04) begin failures++; $display("FAIL rw_oldline_pc got=%h exp=04", inst_pc); end
        redirect_pc = 8'h23;
        step();
        redirect = 1'b0;
        checks++; if (req_addr !== 8'h20) begin failures++; $display("FAIL rw_miss_addr got=%h exp=20", req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rw_miss_valid got=%0b exp=0", inst_valid); end
    endtask

    task automatic test_redirect_resp_coincide();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 8'h08; resp_valid = 1'b1; resp_block = blkb;
        step();
        redirect = 1'b0; resp_valid = 1'b0;
        checks++; if (inst !== 32'h33333333) begin failures++; $display("FAIL co_inst got=%h exp=33333333", inst); end
        checks++; if (inst_pc !== 8'h08) begin failures++; $display("FAIL co_pc got=%h exp=08", inst_pc); end
        redirect = 1'b1; redirect_pc = 8'h23;
        step();
        redirect = 1'b0; req_ready = 1'b1;
        step();
        req_ready = 1'b0; resp_valid = 1'b1; resp_block = blkb;
        step();
        resp_valid = 1'b0;
        checks++; if (inst !== 32'hAAAAAAAA) begin failures++; $display("FAIL co_new_inst got=%h exp=AAAAAAAA", inst); end
        checks++; if (inst_pc !== 8'h20) begin failures++; $display("FAIL co_new_pc got=%h exp=20", inst_pc); end
    endtask

    task automatic test_back_to_back();
        inst_ready = 1'b1;
        step();
        checks++; if (inst !== 32'hBBBBBBBB) begin failures++; $display("FAIL b2b_inst got=%h exp=BBBBBBBB", inst); end
        checks++; if (inst_pc !== 8'h24) begin failures++; $display("FAIL b2b_pc got=%h exp=24", inst_pc); end
        redirect = 1'b1; redirect_pc = 8'h2C;
        step();
        redirect = 1'b0; inst_ready = 1'b0;
        checks++; if (inst !== 32'hDDDDDDDD) begin failures++; $display("FAIL b2b_redir_inst got=%h exp=DDDDDDDD", inst); end
        checks++; if (inst_pc !== 8'h2C) begin failures++; $display("FAIL b2b_redir_pc got=%h exp=2C", inst_pc); end
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0; req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        checks++; if (state_dbg !== S_WAIT) begin failures++; $display("FAIL rm_wait got=%0d exp=%0d", state_dbg, S_WAIT); end
        rst = 1'b1;
        #1;
        checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL rm_async got=%0d exp=%0d", state_dbg, S_IDLE); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rm_req got=%0b exp=0", req_valid); end
        step();
        rst = 1'b0; resp_valid = 1'b1; resp_block = blka;
        step();
        resp_valid = 1'b0;
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL rm_req_after got=%0b exp=1", req_valid); end
        checks++; if (req_addr !== 8'h00) begin failures++; $display("FAIL rm_addr got=%h exp=00", req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b exp=0", inst_valid); end
        step();
        checks++; if (state_dbg !== S_FETCH) begin failures++; $display("FAIL rm_fetch got=%0d exp=%0d", state_dbg, S_FETCH); end
        redirect = 1'b1; redirect_pc = 8'h04;
        step();
        redirect = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rm_lb_cleared got=%0b exp=0", inst_valid); end
        checks++; if (req_addr !== 8'h00) begin failures++; $display("FAIL rm_redir_addr got=%h exp=00", req_addr); end
    endtask

    task automatic test_wrap();
        w_rst = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; redirect = 1'b0; resp_valid = 1'b0;
        step();
        checks++; if (w_req_addr !== 8'hF0) begin failures++; $display("FAIL wrap_first_addr got=%h exp=F0", w_req_addr); end
        step();
        resp_valid = 1'b1; resp_block = blk0;
        step();
        resp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (w_inst !== w0[k]) begin failures++; $display("FAIL wrap%0d_inst got=%h exp=%h", k, w_inst, w0[k]); end
            checks++; if (w_inst_pc !== 8'hF0 + 8'(k * 4)) begin failures++; $display("FAIL wrap%0d_pc got=%h exp=%h", k, w_inst_pc, 8'hF0 + 8'(k * 4)); end
            step();
        end
        checks++; if (w_req_valid !== 1'b1) begin failures++; $display("FAIL wrap_req got=%0b exp=1", w_req_valid); end
        checks++; if (w_req_addr !== 8'h00) begin failures++; $display("FAIL wrap_addr got=%h exp=00", w_req_addr); end
        req_ready = 1'b0; inst_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; w_rst = 1'b1;
        req_ready = 1'b0; resp_valid = 1'b0; resp_block = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        test_reset();
        test_backpressure();
        test_lb_hit();
        test_redirect_wait();
        test_redirect_resp_coincide();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
